cpu_step_ctrl: RTL and testbench
================================

Name: cpu_step_ctrl

Overview:
- Clock-enable source for the CPU core on the board; sits directly upstream of the CPU.
- Turns a raw, bouncing, active-low push-button into exactly one single-cycle `cpu_en` pulse per press (single-step mode).
- Alternatively emits a periodic `cpu_en` pulse from a programmable divider (free-run mode).
- The whole design stays on the single 50 MHz clock; no derived clocks.

Parameters:
- DEBOUNCE_CYCLES, 500_000: consecutive cycles a synchronized key level must differ from the stable level before it is accepted (10 ms at 50 MHz); legal range ≥1.
- RUN_DIV, 1_000_000: `cpu_en` period in cycles in free-run mode; legal range ≥1.

Ports:
- clk  in  1  system clock, single clock domain.
- reset  in  1  synchronous, active-high reset.
- key_n  in  1  raw push-button, active-low, asynchronous to clk, bouncing.
- run_sel  in  1  slide switch, asynchronous: 1 = free-run, 0 = single-step.
- cpu_en  out  1  registered one-cycle CPU clock-enable pulse.
- key_level  out  1  debounced key state, 1 = pressed.
- mode_run  out  1  synchronized run_sel.
- step_count  out  16  count of cpu_en pulses (see Optional Feature).

Behaviour:
- Reset:
  - Synchronous, active-high; all registers are cleared on the clk edge where reset=1.
  - Every output is 0 during reset: cpu_en, key_level, mode_run, step_count=16'h0000.
  - Debounce counter, divider and both synchronizer chains are cleared.
- Synchronizers: key_n and run_sel each pass through a 2-flop chain. ~key_n (pressed=1) feeds the debouncer; run_sel feeds mode_run.
- Debouncer, evaluated each edge:
  - If key_sync == key_level: cnt <= 0.
  - Else if cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - Else: key_level <= key_sync and cnt <= 0.
  - Any bounce back to the stable level restarts the count.
  - Counter width is $clog2(DEBOUNCE_CYCLES), minimum 1 bit.
- Latency: key_n first sampled low at edge k →
  - key_level rises at edge k+1+DEBOUNCE_CYCLES;
  - cpu_en is high for the one cycle following edge k+2+DEBOUNCE_CYCLES.
- Step mode (mode_run=0):
  - cpu_en <= key_level & ~key_level_d, i.e. the rising edge of the debounced level only.
  - A release never pulses. A held key pulses exactly once.
- Run mode (mode_run=1):
  - Divider div counts 0..RUN_DIV-1 and wraps.
  - cpu_en <= (div == RUN_DIV-1).
  - Key edges are ignored; the debouncer keeps running and key_level stays valid.
  - RUN_DIV=1 → cpu_en is held high continuously.
- Mode changes:
  - div is held at 0 whenever mode_run=0.
  - After mode_run rises, the first pulse occurs RUN_DIV cycles later.
  - Run→step: the divider phase is discarded with no trailing pulse.
  - A debounced edge in the same cycle that mode_run falls is honoured, because the source is selected by the current registered mode_run.
- Pulse width: cpu_en is never high for 2+ consecutive cycles, except when RUN_DIV=1.
- Reset mid-operation:
  - Abandons any partial debounce or divider count.
  - A key held down through reset release is seen as a new press and yields exactly one pulse after the debounce latency.

Optional Feature:
- Macro: CPU_STEP_CTRL_STEP_COUNT_EN.
- Defined:
  - step_count increments by 1 on each cycle cpu_en=1.
  - Wraps 16'hFFFF→16'h0000.
  - Cleared by reset.
  - Intended for the hex display in place of r1 during bring-up.
- Undefined:
  - Port still exists, tied to 16'h0000.
  - No counter logic is synthesized.

Test Plan (DEBOUNCE_CYCLES=4, RUN_DIV=5):
- Reset: hold reset=1 for 3 cycles with key_n=0 and run_sel=1 → cpu_en, key_level, mode_run and step_count are all 0 on every cycle.
- Clean press:
  - Stimulus: step mode; key_n driven low just before edge 10, held for 20 cycles, then released.
  - Response: key_level=1 from edge 15; cpu_en=1 only in the cycle after edge 16.
  - No pulse on release; key_level returns to 0 four cycles after the synchronized release.
- Bounce:
  - Stimulus: key_n toggles every 2 cycles for 12 cycles, then stays low for 10 cycles.
  - Response: key_level does not rise during bouncing; exactly one cpu_en pulse overall.
- Free-run:
  - Stimulus: run_sel=1.
  - Response: mode_run rises 2 cycles later; cpu_en pulses every 5th cycle, first pulse 5 cycles after mode_run rises.
  - A debounced press during run adds no pulse.
- Mode switch:
  - Stimulus: run_sel drops 2 cycles after a run pulse; a press follows.
  - Response: no further periodic pulses; the press yields one pulse at the debounce latency.
- Counter (macro defined):
  - 3 presses → step_count=3.
  - Preload via RUN_DIV=1 run for 65 536 cycles → step_count wraps to 0.
  - Macro undefined → step_count=0 throughout.

Source files
------------

// File: rtl/cpu_step_ctrl_if.sv
// Board-side signal bundle for the CPU step controller: raw key and mode switch in,
// clock-enable pulse and status out. master = board/stimulus side, slave = controller.
interface cpu_step_ctrl_if;
    logic        key_n;
    logic        run_sel;
    logic        cpu_en;
    logic        key_level;
    logic        mode_run;
    logic [15:0] step_count;

    modport master (
        output key_n,
        output run_sel,
        input  cpu_en,
        input  key_level,
        input  mode_run,
        input  step_count
    );

    modport slave (
        input  key_n,
        input  run_sel,
        output cpu_en,
        output key_level,
        output mode_run,
        output step_count
    );
endinterface

// File: rtl/cpu_step_ctrl.sv
// CPU clock-enable source: debounced single-step from a push-button or periodic free-run.
// Optional pulse counter on step_count is built only when CPU_STEP_CTRL_STEP_COUNT_EN is defined.
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int RUN_DIV         = 1_000_000
) (
    input  logic           clk,
    input  logic           reset,
    cpu_step_ctrl_if.slave bus
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

    logic             key_meta;
    logic             key_sync;
    logic             run_meta;
    logic             mode_run_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             key_level_q;
    logic             level_nxt;
    logic             key_level_d;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic             cpu_en_q;
    logic             en_nxt;

    always_comb begin
        cnt_nxt   = cnt;
        level_nxt = key_level_q;
        div_nxt   = div;
        en_nxt    = 1'b0;

        // Any sample agreeing with the stable level restarts the debounce window.
        if (key_sync == key_level_q) begin
            cnt_nxt = '0;
        end else if (cnt < CNT_MAX) begin
            cnt_nxt = cnt + CNT_W'(1);
        end else begin
            level_nxt = key_sync;
            cnt_nxt   = '0;
        end

        if (!mode_run_q || div == DIV_MAX) begin
            div_nxt = '0;
        end else begin
            div_nxt = div + DIV_W'(1);
        end

        // Source follows the registered mode, so an edge landing as run drops is kept.
        if (mode_run_q) begin
            en_nxt = (div == DIV_MAX);
        end else begin
            en_nxt = key_level_q & ~key_level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_meta    <= 1'b0;
            key_sync    <= 1'b0;
            run_meta    <= 1'b0;
            mode_run_q  <= 1'b0;
            cnt         <= '0;
            key_level_q <= 1'b0;
            key_level_d <= 1'b0;
            div         <= '0;
            cpu_en_q    <= 1'b0;
        end else begin
            key_meta    <= ~bus.key_n;
            key_sync    <= key_meta;
            run_meta    <= bus.run_sel;
            mode_run_q  <= run_meta;
            cnt         <= cnt_nxt;
            key_level_q <= level_nxt;
            key_level_d <= key_level_q;
            div         <= div_nxt;
            cpu_en_q    <= en_nxt;
        end
    end

    assign bus.cpu_en    = cpu_en_q;
    assign bus.key_level = key_level_q;
    assign bus.mode_run  = mode_run_q;

`ifdef CPU_STEP_CTRL_STEP_COUNT_EN
    logic [15:0] step_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            step_cnt <= 16'h0000;
        end else if (cpu_en_q) begin
            step_cnt <= step_cnt + 16'h0001;
        end
    end

    assign bus.step_count = step_cnt;
`else
    assign bus.step_count = 16'h0000;
`endif

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed + randomized bench for cpu_step_ctrl against a sample-history reference model.
module tb_cpu_step_ctrl;

  localparam int D = 4;
  localparam int R = 5;
`ifdef CPU_STEP_CTRL_STEP_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic reset2;
  always #10 clk = ~clk;

  cpu_step_ctrl_if bus ();
  cpu_step_ctrl_if bus2 ();

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(D), .RUN_DIV(R)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  cpu_step_ctrl #(.DEBOUNCE_CYCLES(1), .RUN_DIV(1)) dut_wrap (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int edge_no  = 0;
  int pulse_q[$];

  // Reference model: history of synchronized key samples, mode run length, pulse count.
  bit          m_hist1, m_sync2, m_run1, m_mode, m_level, m_level_prev, m_cen;
  int          m_runlen;
  logic [15:0] m_cnt;
  bit          m_win[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit all_diff;
    bit nlevel;
    bit ncen;
    int nrun;
    if (reset) begin
      m_hist1 = 0; m_sync2 = 0; m_run1 = 0; m_mode = 0;
      m_level = 0; m_level_prev = 0; m_cen = 0; m_runlen = 0;
      m_cnt = 16'h0000;
      m_win.delete();
    end else begin
      // Level flips once the last D synchronized samples all disagree with it.
      m_win.push_back(m_sync2);
      if (m_win.size() > D) void'(m_win.pop_front());
      all_diff = (m_win.size() == D);
      foreach (m_win[i]) if (m_win[i] == m_level) all_diff = 0;
      nlevel = all_diff ? ~m_level : m_level;
      nrun   = m_mode ? m_runlen + 1 : 0;
      ncen   = m_mode ? ((nrun % R) == 0) : (m_level & ~m_level_prev);
      if (CNT_EN && m_cen) m_cnt = m_cnt + 16'h0001;
      m_sync2      = m_hist1;
      m_hist1      = ~bus.key_n;
      m_mode       = m_run1;
      m_run1       = bus.run_sel;
      m_level_prev = m_level;
      m_level      = nlevel;
      m_runlen     = nrun;
      m_cen        = ncen;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("cpu_en", 32'(bus.cpu_en), 32'(m_cen));
    check("key_level", 32'(bus.key_level), 32'(m_level));
    check("mode_run", 32'(bus.mode_run), 32'(m_mode));
    check("step_count", 32'(bus.step_count), 32'(m_cnt));
    if (bus.cpu_en) pulse_q.push_back(edge_no);
    edge_no++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_release(input int hold, input int idle);
    bus.key_n = 1'b0;
    ticks(hold);
    bus.key_n = 1'b1;
    ticks(idle);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int k;
    int got;
    int len;
    logic [15:0] cnt_before;

    bus.key_n    = 1'b0;
    bus.run_sel  = 1'b1;
    bus2.key_n   = 1'b1;
    bus2.run_sel = 1'b0;
    reset        = 1'b1;
    reset2       = 1'b1;

    // Reset with key pressed and run selected: everything stays at zero.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_cpu_en", 32'(bus.cpu_en), 0);
      check("rst_key_level", 32'(bus.key_level), 0);
      check("rst_mode_run", 32'(bus.mode_run), 0);
      check("rst_step_count", 32'(bus.step_count), 0);
    end
    reset       = 1'b0;
    bus.key_n   = 1'b1;
    bus.run_sel = 1'b0;
    ticks(6);

    // Clean press: level at k+1+D, one pulse at k+2+D.
    pulse_q.delete();
    k = edge_no;
    bus.key_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == D)     check("press_level_before", 32'(bus.key_level), 0);
      if (i == D + 1) check("press_level_rise", 32'(bus.key_level), 1);
      if (i == D + 1) check("press_no_early_pulse", 32'(bus.cpu_en), 0);
      if (i == D + 2) check("press_pulse", 32'(bus.cpu_en), 1);
      if (i == D + 3) check("press_pulse_width", 32'(bus.cpu_en), 0);
    end
    check("press_pulse_count", pulse_q.size(), 1);
    check("press_pulse_edge", (pulse_q.size() > 0) ? pulse_q[0] : -1, k + 2 + D);

    // Release: no pulse, level falls after the debounce latency.
    pulse_q.delete();
    bus.key_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == D)     check("release_level_hold", 32'(bus.key_level), 1);
      if (i == D + 1) check("release_level_fall", 32'(bus.key_level), 0);
    end
    check("release_pulse_count", pulse_q.size(), 0);

    // Bounce: toggles shorter than the debounce window are rejected.
    pulse_q.delete();
    for (int seg = 0; seg < 6; seg++) begin
      bus.key_n = (seg % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      tick();
      check("bounce_level_low", 32'(bus.key_level), 0);
    end
    press_release(10, 10);
    check("bounce_pulse_count", pulse_q.size(), 1);

    // Free-run: pulses every R cycles, key presses ignored.
    pulse_q.delete();
    k = edge_no;
    bus.run_sel = 1'b1;
    tick();
    check("run_mode_lag", 32'(bus.mode_run), 0);
    tick();
    check("run_mode_rise", 32'(bus.mode_run), 1);
    for (int i = 0; i < 30; i++) begin
      if (i == 5)  bus.key_n = 1'b0;
      if (i == 20) bus.key_n = 1'b1;
      tick();
    end
    check("run_pulse_count", pulse_q.size(), 6);
    check("run_first_pulse", (pulse_q.size() > 0) ? pulse_q[0] : -1, k + 1 + R);
    for (int i = 1; i < pulse_q.size(); i++)
      check("run_pulse_period", pulse_q[i] - pulse_q[i-1], R);

    // Mode switch two cycles after a run pulse: no trailing pulse, then a step press.
    got = 0;
    for (int i = 0; i < 2 * R && got == 0; i++) begin
      tick();
      if (bus.cpu_en) got = 1;
    end
    check("switch_run_pulse_seen", got, 1);
    tick();
    bus.run_sel = 1'b0;
    pulse_q.delete();
    ticks(8);
    check("switch_no_trailing", pulse_q.size(), 0);
    k = edge_no;
    press_release(12, 10);
    check("switch_press_count", pulse_q.size(), 1);
    check("switch_press_edge", (pulse_q.size() > 0) ? pulse_q[0] : -1, k + 2 + D);

    // Three more presses advance the counter by three.
    cnt_before = m_cnt;
    for (int p = 0; p < 3; p++) press_release(8, 8);
    check("count_three", 32'(bus.step_count), CNT_EN ? 32'(cnt_before + 16'd3) : 0);

    // Random key/mode activity with one mid-run reset.
    for (int seg = 0; seg < 60; seg++) begin
      bus.key_n = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 7) == 0) bus.run_sel = ~bus.run_sel;
      if (seg == 30) begin
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
      end
      ticks(len);
    end

    // Key held through reset release counts as a fresh press.
    bus.run_sel = 1'b0;
    bus.key_n   = 1'b0;
    reset       = 1'b1;
    ticks(2);
    reset = 1'b0;
    pulse_q.delete();
    k = edge_no;
    ticks(14);
    check("held_reset_count", pulse_q.size(), 1);
    check("held_reset_edge", (pulse_q.size() > 0) ? pulse_q[0] : -1, k + 2 + D);
    bus.key_n = 1'b1;
    ticks(10);

    // Continuous run with RUN_DIV=1: counter passes 16'hFFFF and wraps.
    bus2.run_sel = 1'b1;
    tick();
    reset2 = 1'b0;
    for (int j = 1; j <= 65540; j++) begin
      tick();
      if (j == 2) check("wrap_mode_run", 32'(bus2.mode_run), 1);
      if (j == 2) check("wrap_cpu_en_lag", 32'(bus2.cpu_en), 0);
      if (j == 3) check("wrap_cpu_en_on", 32'(bus2.cpu_en), 1);
      if (j == 1000) check("wrap_cpu_en_held", 32'(bus2.cpu_en), 1);
      if (j == 10 || j == 65538 || j == 65539 || j == 65540)
        check("wrap_step_count", 32'(bus2.step_count), CNT_EN ? 32'(16'(j - 3)) : 0);
    end
    check("wrap_key_level", 32'(bus2.key_level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
